// File: rtl/seq_div_16_8.sv
// Iterative unsigned restoring divider: WIDTH_N-bit dividend by WIDTH_D-bit divisor,
// one quotient bit per clock, valid/ready handshake on both sides.
module seq_div_16_8 #(
  parameter int unsigned WIDTH_N = 16,
  parameter int unsigned WIDTH_D = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH_N);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e             state_q, state_d;
  // Working dividend; quotient bits shift in at the LSB as dividend bits leave the MSB.
  logic [WIDTH_N-1:0] dvd_q, dvd_d;
  logic [WIDTH_D-1:0] dvs_q, dvs_d;
  logic [WIDTH_D:0]   pr_q, pr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH_N-1:0] quo_q, quo_d;
  logic [WIDTH_D-1:0] rem_q, rem_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH_D:0]   pr_shift;
  logic [WIDTH_D:0]   pr_diff;
  logic               fits;
  logic [WIDTH_D:0]   step_pr;
  logic [WIDTH_N-1:0] step_dvd;

  always_comb begin
    pr_shift = (pr_q << 1) | {{WIDTH_D{1'b0}}, dvd_q[WIDTH_N-1]};
    pr_diff  = pr_shift - {1'b0, dvs_q};
    fits     = (pr_shift >= {1'b0, dvs_q});
    step_pr  = fits ? pr_diff : pr_shift;
    step_dvd = {dvd_q[WIDTH_N-2:0], fits};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          dvd_d = dividend;
          dvs_d = divisor;
          pr_d  = '0;
          cnt_d = CntW'(WIDTH_N - 1);
          if (divisor == '0) begin
            // Zero divisor skips iteration and publishes the fixed result at once.
            quo_d   = '1;
            rem_d   = dividend[WIDTH_D-1:0];
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        dvd_d = step_dvd;
        pr_d  = step_pr;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          // Remainder is always below the divisor, so its top bit is zero here.
          quo_d   = step_dvd;
          rem_d   = step_pr[WIDTH_D-1:0];
          dbz_d   = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_16_8.sv
// Self-checking bench for seq_div_16_8: directed table, backpressure, mid-run reset,
// and a randomized stream checked against plain integer division.
module tb_seq_div_16_8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  seq_div_16_8 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Offers one operand pair, waits for the result and samples it.
  // lat counts rising edges after the accepting edge until out_valid is seen
  // (a zero divisor is published by the accepting edge itself, giving 0).
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input bit consume,
                       output logic [15:0] q, output logic [7:0] r, output logic z,
                       output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  vec_t        vecs[8];
  logic [15:0] q, eq, cq;
  logic [7:0]  r, er, cr;
  logic        z, ez, cz;
  int          lat;

  initial begin
    vecs[0] = '{a: 16'd50000, b: 8'd200, q: 16'd250,   r: 8'd0,    z: 1'b0, lat: 16};
    vecs[1] = '{a: 16'd43690, b: 8'd255, q: 16'd171,   r: 8'd85,   z: 1'b0, lat: 16};
    vecs[2] = '{a: 16'd65535, b: 8'd1,   q: 16'd65535, r: 8'd0,    z: 1'b0, lat: 16};
    vecs[3] = '{a: 16'd0,     b: 8'd7,   q: 16'd0,     r: 8'd0,    z: 1'b0, lat: 16};
    vecs[4] = '{a: 16'd1000,  b: 8'd0,   q: 16'hFFFF,  r: 8'hE8,   z: 1'b1, lat: 0};
    vecs[5] = '{a: 16'd100,   b: 8'd7,   q: 16'd14,    r: 8'd2,    z: 1'b0, lat: 16};
    vecs[6] = '{a: 16'd65535, b: 8'd255, q: 16'd257,   r: 8'd0,    z: 1'b0, lat: 16};
    vecs[7] = '{a: 16'd254,   b: 8'd255, q: 16'd0,     r: 8'd254,  z: 1'b0, lat: 16};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, 1'b1, q, r, z, lat);
      check($sformatf("vec%0d_quotient", i), 32'(q), 32'(vecs[i].q));
      check($sformatf("vec%0d_remainder", i), 32'(r), 32'(vecs[i].r));
      check($sformatf("vec%0d_dbz", i), 32'(z), 32'(vecs[i].z));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_in_ready_after", i), 32'(in_ready), 32'd1);
    end

    // Backpressure: result held, no new acceptance while in DONE
    do_op(16'd50000, 8'd200, 1'b0, q, r, z, lat);
    in_valid = 1'b1;
    dividend = 16'd1234;
    divisor  = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_quotient", 32'(quotient), 32'd250);
      check("bp_remainder", 32'(remainder), 32'd0);
      check("bp_dbz", 32'(div_by_zero), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp_not_accepted", 32'(in_ready), 32'd1);

    // Asynchronous reset during the 8th RUN step
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'd50000;
    divisor  = 8'd200;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_quotient", 32'(quotient), 32'd0);
    check("rst_mid_remainder", 32'(remainder), 32'd0);
    check("rst_mid_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'd100, 8'd7, 1'b1, q, r, z, lat);
    check("post_rst_quotient", 32'(q), 32'd14);
    check("post_rst_remainder", 32'(r), 32'd2);
    check("post_rst_latency", 32'(lat), 32'd16);

    // Randomized stream against a plain-arithmetic model, random out_ready
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      bit          got, stable, done;
      int          n;
      a = 16'($urandom);
      if (i % 8 == 0) b = 8'd0;
      else if ($urandom_range(0, 15) == 0) b = 8'd1;
      else b = 8'($urandom);
      if (b == 8'd0) begin
        eq = 16'hFFFF;
        er = a[7:0];
        ez = 1'b1;
      end else begin
        eq = a / {8'd0, b};
        er = 8'(a % {8'd0, b});
        ez = 1'b0;
      end

      @(negedge clk);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      n = 0;
      while (!in_ready && n < 64) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);

      got = 1'b0;
      stable = 1'b1;
      done = 1'b0;
      cq = '0;
      cr = '0;
      cz = 1'b0;
      n = 0;
      while (!done && n < 200) begin
        if (out_valid) begin
          if (!got) begin
            cq = quotient;
            cr = remainder;
            cz = div_by_zero;
          end else if (quotient !== cq || remainder !== cr || div_by_zero !== cz) begin
            stable = 1'b0;
          end
          got = 1'b1;
        end
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) done = 1'b1;
        @(posedge clk);
        #1;
        n++;
      end
      out_ready = 1'b0;
      check($sformatf("rand%0d_done", i), 32'(done), 32'd1);
      check($sformatf("rand%0d_quotient a=%0d b=%0d", i, a, b), 32'(cq), 32'(eq));
      check($sformatf("rand%0d_remainder a=%0d b=%0d", i, a, b), 32'(cr), 32'(er));
      check($sformatf("rand%0d_dbz", i), 32'(cz), 32'(ez));
      check($sformatf("rand%0d_stable", i), 32'(stable), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
